// File: rtl/ram_dma_copy_pkg.sv
// Shared widths, RAM size and FSM encoding for the RAM512 block-copy engine.
// FILL only exists in the encoding when RAM_DMA_FILL_EN is defined.
package ram_dma_copy_pkg;
  localparam int ADDR_W_D  = 9;
  localparam int DATA_W_D  = 16;
  localparam int LEN_W_D   = 10;
  localparam int RAM_WORDS = 512;

`ifdef RAM_DMA_FILL_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FIN   = 3'd3,
    S_FILL  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_t;
`endif
endpackage

// File: rtl/dma_addr_ctr.sv
// Loadable wrapping address counter; load has priority over increment.
module dma_addr_ctr #(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/ram_dma_copy.sv
// RAM512 block copy engine: one read cycle then one write cycle per word.
// Optional RAM_DMA_FILL_EN adds a one-cycle-per-word pattern fill mode.
module ram_dma_copy
  import ram_dma_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int LEN_W  = LEN_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic              fill,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] ram_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic              busy,
  output logic              done
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(RAM_WORDS);

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_buf;
  logic [ADDR_W-1:0] w_src_cur;
  logic [ADDR_W-1:0] w_dst_cur;
  logic [LEN_W-1:0]  w_len_eff;
  logic              w_accept;
  logic              w_src_en;
  logic              w_dst_en;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_len_eff = (len > MAX_LEN) ? MAX_LEN : len;

`ifdef RAM_DMA_FILL_EN
  logic [DATA_W-1:0] r_pat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_pat <= '0;
    else if (w_accept) r_pat <= pattern;
  end
`else
  logic w_unused;
  assign w_unused = ^{fill, pattern};
`endif

  dma_addr_ctr #(.W(ADDR_W)) u_src_ctr (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_load (w_accept),
    .i_val  (src),
    .i_en   (w_src_en),
    .o_cnt  (w_src_cur)
  );

  dma_addr_ctr #(.W(ADDR_W)) u_dst_ctr (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_load (w_accept),
    .i_val  (dst),
    .i_en   (w_dst_en),
    .o_cnt  (w_dst_cur)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)                r_rem <= w_len_eff;
      else if (w_dst_en)           r_rem <= r_rem - LEN_W'(1);
      if (r_state == S_READ)       r_buf <= ram_out;
    end
  end

  // Outputs are decoded from state so an async reset clears them immediately.
  always_comb begin
    w_next   = r_state;
    ram_addr = '0;
    ram_in   = '0;
    ram_load = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    w_src_en = 1'b0;
    w_dst_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) w_next = S_FIN;
`ifdef RAM_DMA_FILL_EN
          else if (fill) w_next = S_FILL;
`endif
          else           w_next = S_READ;
        end
      end
      S_READ: begin
        busy     = 1'b1;
        ram_addr = w_src_cur;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        ram_addr = w_dst_cur;
        ram_in   = r_buf;
        ram_load = 1'b1;
        w_src_en = 1'b1;
        w_dst_en = 1'b1;
        w_next   = (r_rem == LEN_W'(1)) ? S_FIN : S_READ;
      end
`ifdef RAM_DMA_FILL_EN
      S_FILL: begin
        busy     = 1'b1;
        ram_addr = w_dst_cur;
        ram_in   = r_pat;
        ram_load = 1'b1;
        w_dst_en = 1'b1;
        w_next   = (r_rem == LEN_W'(1)) ? S_FIN : S_FILL;
      end
`endif
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
